debug_display: RTL and testbench

Board-level debug readout that sits directly downstream of the pipelined MIPS top level. It consumes that top level's debug taps (program counter, write-back data, HI, LO) and time-multiplexes one selected 32-bit value as eight hex digits onto a common-anode 7-segment display. A frame-aligned snapshot register keeps all eight digits coherent while the pipeline keeps running. A freeze input holds the current value for inspection.

---
 rtl/debug_display_pkg.sv | 51 +++++
 rtl/debug_display_hex_to_seg7.sv | 22 ++
 rtl/debug_display.sv | 145 ++++++++++++++
 tb/tb_debug_display.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_display_pkg.sv
// debug_display_pkg
//   Shared constants for the debug_display block: source-select codes, segment patterns for
//   the common-anode 7-segment display (active-low, bit order {g,f,e,d,c,b,a}), the hex font
//   and a helper for sizing the refresh prescaler.
package debug_display_pkg;

    // Source-select codes for the Sel input.
    localparam logic [1:0] SRC_PC = 2'd0;
    localparam logic [1:0] SRC_WB = 2'd1;
    localparam logic [1:0] SRC_HI = 2'd2;
    localparam logic [1:0] SRC_LO = 2'd3;

    localparam int unsigned NUM_DIGITS = 8;

    // Segment patterns, active-low {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // Anode pattern with digit 0 selected (scan index 0).
    localparam logic [7:0] AN_DIGIT0 = 8'b1111_1110;

    // Standard hex font; lower-case b and d keep them distinct from 8 and 0.
    function automatic logic [6:0] hex_font(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Prescaler width: $clog2 of the divider, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/debug_display_hex_to_seg7.sv
// hex_to_seg7
//   Combinational hex-digit to 7-segment decoder with a blank override.
//   Ports:
//     nibble  in  4  hex value to display
//     blank   in  1  high forces all segments off
//     seg     out 7  active-low segments {g,f,e,d,c,b,a}
module hex_to_seg7
    import debug_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_font(nibble);
        if (blank) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/debug_display.sv
// debug_display
//   Time-multiplexed hex readout of one 32-bit pipeline debug tap on an 8-digit
//   common-anode 7-segment display. The selected source is captured into a snapshot only at
//   frame boundaries, so all eight digits of one scan always come from the same value.
//   Ports:
//     Clk                    in  1   system clock (shared with the pipeline)
//     Reset                  in  1   asynchronous, active-high
//     Debug_Program_Counter  in  32  source 0
//     Debug_Write_Register   in  32  source 1
//     Debug_HI               in  32  source 2
//     Debug_LO               in  32  source 3
//     Sel                    in  2   source select
//     Freeze                 in  1   high blocks snapshot loads at frame boundaries
//     An                     out 8   anode enables, active-low, bit k = digit k (0 rightmost)
//     Seg                    out 7   segments {g,f,e,d,c,b,a}, active-low
//     Dp                     out 1   decimal point, active-low (lit on digit 0 while frozen)
module debug_display
    import debug_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV   = 100000,
    parameter bit          BLANK_LEADING = 1'b0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Debug_Program_Counter,
    input  logic [31:0] Debug_Write_Register,
    input  logic [31:0] Debug_HI,
    input  logic [31:0] Debug_LO,
    input  logic [1:0]  Sel,
    input  logic        Freeze,
    output logic [7:0]  An,
    output logic [6:0]  Seg,
    output logic        Dp
);

    localparam int unsigned CW = cnt_width(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] presc_q;
    logic          tick;
    logic [2:0]    index_q;
    logic          frame_end;
    logic [31:0]   snapshot_q;
    logic          freeze_q;
    logic [31:0]   source;

    // ---------------------------------------------------------------------------------------
    // Refresh prescaler: one tick per digit slot.
    // ---------------------------------------------------------------------------------------
    assign tick = (presc_q == CNT_LAST);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Digit scan index; wraps 7 -> 0 naturally in 3 bits.
    // ---------------------------------------------------------------------------------------
    assign frame_end = tick && (index_q == 3'd7);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            index_q <= 3'd0;
        end else if (tick) begin
            index_q <= index_q + 3'd1;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Source mux and frame-aligned snapshot / freeze flag.
    // ---------------------------------------------------------------------------------------
    always_comb begin
        source = Debug_Program_Counter;
        case (Sel)
            SRC_PC:  source = Debug_Program_Counter;
            SRC_WB:  source = Debug_Write_Register;
            SRC_HI:  source = Debug_HI;
            SRC_LO:  source = Debug_LO;
            default: source = Debug_Program_Counter;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            snapshot_q <= '0;
            freeze_q   <= 1'b0;
        end else if (frame_end) begin
            freeze_q <= Freeze;
            if (!Freeze) begin
                snapshot_q <= source;
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Digit decode. upper_zero[k] is set when nibbles k..7 are all zero, which is exactly the
    // leading-zero condition for digit k.
    // ---------------------------------------------------------------------------------------
    logic [7:0] upper_zero;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_upper_zero
        assign upper_zero[k] = ~|snapshot_q[31:4*k];
    end

    logic [3:0] nibble;
    logic       blank;
    logic [6:0] seg_next;
    logic [7:0] an_next;
    logic       dp_next;

    assign nibble = snapshot_q[{index_q, 2'b00} +: 4];
    // Digit 0 is never blanked so a zero value still shows a single 0.
    assign blank  = BLANK_LEADING && (index_q != 3'd0) && upper_zero[index_q];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble),
        .blank  (blank),
        .seg    (seg_next)
    );

    assign an_next = ~(8'd1 << index_q);
    assign dp_next = ~(freeze_q && (index_q == 3'd0));

    // ---------------------------------------------------------------------------------------
    // Registered outputs: one cycle behind the scan index and snapshot.
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            An  <= AN_DIGIT0;
            Seg <= SEG_ZERO;
            Dp  <= 1'b1;
        end else begin
            An  <= an_next;
            Seg <= seg_next;
            Dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_debug_display.sv
// tb_debug_display
//   Self-checking bench for debug_display. Three instances share stimulus:
//     inst 0: REFRESH_DIV=4, BLANK_LEADING=0
//     inst 1: REFRESH_DIV=4, BLANK_LEADING=1
//     inst 2: REFRESH_DIV=1, BLANK_LEADING=0
//   A cycle model pushes expected outputs per instance at each rising edge; a checker pops
//   and compares them shortly after. Directed scenario checks use literal expected glyphs.
module tb_debug_display;

    logic        clk;
    logic        rst;
    logic [31:0] pc, wb, hi, lo;
    logic [1:0]  sel;
    logic        frz;

    logic [7:0] an_w  [3];
    logic [6:0] seg_w [3];
    logic       dp_w  [3];

    int checks = 0;
    int errors = 0;

    debug_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) u_dut0 (
        .Clk(clk), .Reset(rst), .Debug_Program_Counter(pc), .Debug_Write_Register(wb),
        .Debug_HI(hi), .Debug_LO(lo), .Sel(sel), .Freeze(frz),
        .An(an_w[0]), .Seg(seg_w[0]), .Dp(dp_w[0])
    );
    debug_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) u_dut1 (
        .Clk(clk), .Reset(rst), .Debug_Program_Counter(pc), .Debug_Write_Register(wb),
        .Debug_HI(hi), .Debug_LO(lo), .Sel(sel), .Freeze(frz),
        .An(an_w[1]), .Seg(seg_w[1]), .Dp(dp_w[1])
    );
    debug_display #(.REFRESH_DIV(1), .BLANK_LEADING(1'b0)) u_dut2 (
        .Clk(clk), .Reset(rst), .Debug_Program_Counter(pc), .Debug_Write_Register(wb),
        .Debug_HI(hi), .Debug_LO(lo), .Sel(sel), .Freeze(frz),
        .An(an_w[2]), .Seg(seg_w[2]), .Dp(dp_w[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------------------------
    // Reference model and scoreboard
    // ---------------------------------------------------------------------------------------
    typedef struct {
        int         inst;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t sb[$];

    logic [6:0] font [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int unsigned div_m [3] = '{4, 4, 1};
    bit          bl_m  [3] = '{1'b0, 1'b1, 1'b0};
    int unsigned m_cnt  [3];
    int unsigned m_idx  [3];
    logic [31:0] m_snap [3];
    logic        m_frz  [3];

    always @(posedge clk) begin
        exp_t        e;
        logic [31:0] src;
        logic [31:0] upper;
        bit          tick;
        for (int i = 0; i < 3; i++) begin
            e.inst = i;
            if (rst) begin
                m_cnt[i]  = 0;
                m_idx[i]  = 0;
                m_snap[i] = 32'h0;
                m_frz[i]  = 1'b0;
                e.an  = 8'hFE;
                e.seg = 7'b1000000;
                e.dp  = 1'b1;
            end else begin
                upper = m_snap[i] >> (4 * m_idx[i]);
                e.an  = ~(8'd1 << m_idx[i]);
                e.seg = (bl_m[i] && m_idx[i] != 0 && upper == 0) ? 7'h7F : font[upper[3:0]];
                e.dp  = !(m_idx[i] == 0 && m_frz[i]);
                case (sel)
                    2'd0:    src = pc;
                    2'd1:    src = wb;
                    2'd2:    src = hi;
                    default: src = lo;
                endcase
                tick = (m_cnt[i] == div_m[i] - 1);
                if (tick && m_idx[i] == 7) begin
                    if (!frz) m_snap[i] = src;
                    m_frz[i] = frz;
                end
                m_cnt[i] = tick ? 0 : m_cnt[i] + 1;
                if (tick) m_idx[i] = (m_idx[i] + 1) % 8;
            end
            sb.push_back(e);
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #2;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq($sformatf("sb_an%0d", e.inst),  {24'h0, an_w[e.inst]},  {24'h0, e.an});
            check_eq($sformatf("sb_seg%0d", e.inst), {25'h0, seg_w[e.inst]}, {25'h0, e.seg});
            check_eq($sformatf("sb_dp%0d", e.inst),  {31'h0, dp_w[e.inst]},  {31'h0, e.dp});
        end
    end

    // ---------------------------------------------------------------------------------------
    // Directed helpers
    // ---------------------------------------------------------------------------------------
    logic [6:0] cap_seg [8];
    logic       cap_dp0;

    // Record the glyph shown on each digit over a window of cycles.
    task automatic capture(input int inst, input int cycles);
        for (int k = 0; k < 8; k++) cap_seg[k] = 7'bx;
        cap_dp0 = 1'bx;
        repeat (cycles) begin
            @(posedge clk);
            #3;
            for (int k = 0; k < 8; k++) begin
                if (an_w[inst] == ~(8'd1 << k)) begin
                    cap_seg[k] = seg_w[inst];
                    if (k == 0) cap_dp0 = dp_w[inst];
                end
            end
        end
    endtask

    task automatic check_digit(input string tag, input int k, input logic [6:0] exp);
        check_eq($sformatf("%s_d%0d", tag, k), {25'h0, cap_seg[k]}, {25'h0, exp});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Count edges after release until digit 1 is selected on inst 0.
    task automatic first_change(input string tag);
        int n;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (an_w[0] == 8'hFD) break;
        end
        check_eq(tag, n, 5);
    endtask

    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000, G4 = 7'b0011001, GA = 7'b0001000;
    localparam logic [6:0] GB = 7'b0000011, GD = 7'b0100001, GE = 7'b0000110;
    localparam logic [6:0] GF = 7'b0001110, GX = 7'b1111111;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] exp_he [8];
        int guard;

        rst = 1'b0;
        pc  = 32'h0040_00A4;
        wb  = 32'h0;
        hi  = 32'hDEAD_BEEF;
        lo  = 32'h1;
        sel = 2'd0;
        frz = 1'b0;
        #1 rst = 1'b1;

        // Reset hold.
        wait_cycles(3);
        check_eq("rst_an",  {24'h0, an_w[0]},  32'hFE);
        check_eq("rst_seg", {25'h0, seg_w[0]}, 32'h40);
        check_eq("rst_dp",  {31'h0, dp_w[0]},  32'h1);
        rst = 1'b0;
        first_change("first_an_change");

        // PC readout.
        wait_cycles(40);
        capture(0, 32);
        check_digit("pc", 0, G4);
        check_digit("pc", 1, GA);
        check_digit("pc", 5, G4);
        check_digit("pc", 2, G0);
        check_digit("pc", 7, G0);
        capture(2, 8);
        check_digit("pc_div1", 0, G4);
        check_digit("pc_div1", 1, GA);
        check_digit("pc_div1", 3, G0);

        // Switch to HI mid-frame.
        wait_cycles(13);
        sel = 2'd2;
        wait_cycles(40);
        capture(0, 32);
        exp_he = '{GF, GE, GE, GB, GD, GA, GE, GD};
        for (int k = 0; k < 8; k++) check_digit("hi", k, exp_he[k]);

        // Freeze across a boundary while LO changes.
        sel = 2'd3;
        lo  = 32'h1;
        wait_cycles(40);
        frz = 1'b1;
        wait_cycles(40);
        lo = 32'h2;
        wait_cycles(40);
        capture(0, 32);
        check_digit("frozen", 0, G1);
        check_eq("frozen_dp", {31'h0, cap_dp0}, 32'h0);
        frz = 1'b0;
        wait_cycles(40);
        capture(0, 32);
        check_digit("thawed", 0, G2);
        check_eq("thawed_dp", {31'h0, cap_dp0}, 32'h1);

        // Leading-zero blanking.
        sel = 2'd1;
        wb  = 32'h0000_0030;
        wait_cycles(40);
        capture(1, 32);
        check_digit("blank", 0, G0);
        check_digit("blank", 1, G3);
        for (int k = 2; k < 8; k++) check_digit("blank", k, GX);
        capture(0, 32);
        check_digit("noblank", 4, G0);
        wb = 32'h0;
        wait_cycles(40);
        capture(1, 32);
        check_digit("zero", 0, G0);
        for (int k = 1; k < 8; k++) check_digit("zero", k, GX);

        // Reset mid-frame at index 5.
        wb = 32'h1234_5678;
        wait_cycles(40);
        guard = 0;
        while (an_w[0] != 8'hDF && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check_eq("reach_idx5", {24'h0, an_w[0]}, 32'hDF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("async_an",  {24'h0, an_w[0]},  32'hFE);
        check_eq("async_seg", {25'h0, seg_w[0]}, 32'h40);
        check_eq("async_dp",  {31'h0, dp_w[0]},  32'h1);
        wait_cycles(2);
        rst = 1'b0;
        first_change("resume_an_change");
        capture(0, 20);
        for (int k = 1; k < 4; k++) check_digit("post_rst", k, G0);

        wait_cycles(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
